// File: rtl/mul_seq_arbiter_if.sv
// rtl/mul_seq_arbiter_if.sv - requester/result bundle for the shared constant-multiple arbiter
interface mul_seq_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int OW   = DW + 3
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    grant;
    logic               out_valid;
    logic               out_ready;
    logic [OW-1:0]      out_data;
    logic [1:0]         out_sel;
    logic [IW-1:0]      out_id;
    logic               out_last;
    logic               busy;

    // Requesters and the result consumer
    modport master (
        output req, data, out_ready,
        input  grant, out_valid, out_data, out_sel, out_id, out_last, busy
    );

    // The arbiter itself
    modport slave (
        input  req, data, out_ready,
        output grant, out_valid, out_data, out_sel, out_id, out_last, busy
    );
endinterface

// File: rtl/mul_seq_arbiter.sv
// rtl/mul_seq_arbiter.sv - round-robin arbiter feeding a x1/x3/x7/x8 shift-add burst sequencer
module mul_seq_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int OW   = DW + 3
) (
    input  logic             clk,
    input  logic             rst,
    mul_seq_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [1:0]      step, step_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [DW-1:0]   d_reg, d_nxt;
    logic [NREQ-1:0] grant_q, grant_nxt;
    logic            valid_q, valid_nxt;
    logic [OW-1:0]   data_q, data_nxt;
    logic [1:0]      sel_q, sel_nxt;
    logic [IW-1:0]   id_q, id_nxt;
    logic            last_beat_q, last_beat_nxt;

    logic [IW-1:0]   winner;
    logic [IW-1:0]   idx;
    logic            found;

    // Shift-add products; the operand is widened first so x8 never truncates
    function automatic logic [OW-1:0] product(input logic [DW-1:0] d, input logic [1:0] sel);
        logic [OW-1:0] x;
        x = OW'(d);
        case (sel)
            2'd0:    product = x;
            2'd1:    product = x + (x << 1);
            2'd2:    product = x + (x << 1) + (x << 2);
            default: product = x << 3;
        endcase
    endfunction

    // Round-robin search starting one past the last winner; IW-bit index wraps naturally
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last + IW'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output decode; everything holds unless a grant or an accepted beat moves it
    always_comb begin
        state_nxt     = state;
        step_nxt      = step;
        last_nxt      = last;
        d_nxt         = d_reg;
        grant_nxt     = '0;
        valid_nxt     = valid_q;
        data_nxt      = data_q;
        sel_nxt       = sel_q;
        id_nxt        = id_q;
        last_beat_nxt = last_beat_q;
        case (state)
            IDLE: begin
                if (found) begin
                    d_nxt         = bus.data[winner*DW +: DW];
                    grant_nxt     = NREQ'(1) << winner;
                    last_nxt      = winner;
                    id_nxt        = winner;
                    step_nxt      = 2'd0;
                    sel_nxt       = 2'd0;
                    data_nxt      = product(d_nxt, 2'd0);
                    valid_nxt     = 1'b1;
                    last_beat_nxt = 1'b0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (valid_q && bus.out_ready) begin
                    if (step != 2'd3) begin
                        step_nxt      = step + 2'd1;
                        sel_nxt       = step + 2'd1;
                        data_nxt      = product(d_reg, step + 2'd1);
                        last_beat_nxt = (step == 2'd2);
                    end else begin
                        step_nxt      = 2'd0;
                        valid_nxt     = 1'b0;
                        last_beat_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset points the arbiter so req[0] wins first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            step        <= 2'd0;
            last        <= IW'(NREQ - 1);
            d_reg       <= '0;
            grant_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            sel_q       <= 2'd0;
            id_q        <= '0;
            last_beat_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            step        <= step_nxt;
            last        <= last_nxt;
            d_reg       <= d_nxt;
            grant_q     <= grant_nxt;
            valid_q     <= valid_nxt;
            data_q      <= data_nxt;
            sel_q       <= sel_nxt;
            id_q        <= id_nxt;
            last_beat_q <= last_beat_nxt;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_id    = id_q;
    assign bus.out_last  = last_beat_q;
    assign bus.busy      = (state == RUN);
endmodule

// File: tb/tb_mul_seq_arbiter.sv
// tb/tb_mul_seq_arbiter.sv - scoreboard bench for mul_seq_arbiter
module tb_mul_seq_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int OW   = 11;

    typedef struct packed {
        logic [OW-1:0] d;
        logic [1:0]    s;
        logic [1:0]    id;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    beat_t           exp_q[$];
    logic [NREQ-1:0] gnt_q[$];
    beat_t           mon_b;
    logic [NREQ-1:0] mon_g;

    mul_seq_arbiter_if #(.NREQ(NREQ), .DW(DW), .OW(OW)) bus ();

    mul_seq_arbiter #(.NREQ(NREQ), .DW(DW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int id, input int d);
        bus.data[id*DW +: DW] = DW'(d);
    endtask

    task automatic push_job(input int id, input int d);
        beat_t b;
        int    m;
        gnt_q.push_back(4'b0001 << id);
        for (int s = 0; s < 4; s++) begin
            m    = (s == 0) ? 1 : (s == 1) ? 3 : (s == 2) ? 7 : 8;
            b.d  = OW'(d * m);
            b.s  = 2'(s);
            b.id = 2'(id);
            b.l  = (s == 3);
            exp_q.push_back(b);
        end
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && (exp_q.size() != 0 || gnt_q.size() != 0 || bus.out_valid); i++)
            cyc(1);
        chk(tag, {29'd0, exp_q.size() != 0, gnt_q.size() != 0, bus.out_valid}, 0);
    endtask

    task automatic wait_grants(input string tag, input int bound);
        for (int i = 0; i < bound && gnt_q.size() != 0; i++)
            cyc(1);
        chk(tag, gnt_q.size(), 0);
    endtask

    // Scoreboard: every grant and every accepted beat is popped and compared
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.grant !== '0) begin
                chk("grant_expected", gnt_q.size() != 0, 1);
                mon_g = (gnt_q.size() != 0) ? gnt_q.pop_front() : '0;
                chk("grant_order", bus.grant, mon_g);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                mon_b = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                chk("beat_data", bus.out_data, mon_b.d);
                chk("beat_sel", bus.out_sel, mon_b.s);
                chk("beat_id", bus.out_id, mon_b.id);
                chk("beat_last", bus.out_last, mon_b.l);
            end
        end
    end

    initial begin
        rst           = 1'b0;
        bus.req       = '0;
        bus.data      = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_data", bus.out_data, 0);
        cyc(2);
        rst = 1'b1;

        // single job, cycle-accurate
        set_data(2, 5);
        bus.req = 4'b0100;
        push_job(2, 5);
        cyc(1);
        chk("t1_grant", bus.grant, 4'b0100);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 5);
        chk("t1_busy", bus.busy, 1);
        bus.req = '0;
        cyc(1);
        chk("t2_grant", bus.grant, 0);
        cyc(2);
        chk("t4_last", bus.out_last, 1);
        cyc(1);
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_busy", bus.busy, 0);
        drain("drain_single", 10);

        // max operand
        set_data(0, 255);
        bus.req = 4'b0001;
        push_job(0, 255);
        cyc(1);
        bus.req = '0;
        drain("drain_max", 20);

        // backpressure on the sel=1 beat
        set_data(1, 5);
        bus.req = 4'b0010;
        push_job(1, 5);
        cyc(1);
        bus.req = '0;
        cyc(1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("bp_data", bus.out_data, 15);
            chk("bp_sel", bus.out_sel, 1);
        end
        bus.out_ready = 1'b1;
        cyc(1);
        chk("bp_resume", bus.out_data, 35);
        drain("drain_bp", 20);

        // contention from reset
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_data(i, 17 + 40 * i);
        bus.req = 4'b1111;
        push_job(0, 17);
        push_job(1, 57);
        push_job(2, 97);
        push_job(3, 137);
        push_job(0, 17);
        wait_grants("wait_contention", 60);
        bus.req = '0;
        drain("drain_contention", 20);

        // wraparound with gaps
        set_data(3, 7);
        bus.req = 4'b1000;
        push_job(3, 7);
        cyc(1);
        bus.req = '0;
        drain("drain_wrap_a", 20);
        set_data(0, 9);
        bus.req = 4'b1001;
        push_job(0, 9);
        push_job(3, 7);
        wait_grants("wait_wrap", 30);
        bus.req = '0;
        drain("drain_wrap_b", 20);

        // reset in the middle of a burst
        set_data(2, 6);
        bus.req = 4'b0100;
        push_job(2, 6);
        cyc(1);
        bus.req = '0;
        for (int i = 0; i < 10 && !(bus.out_valid && bus.out_sel == 2'd2); i++)
            cyc(1);
        chk("mid_sel", bus.out_sel, 2);
        exp_q.delete();
        gnt_q.delete();
        rst = 1'b0;
        #1;
        chk("mid_valid", bus.out_valid, 0);
        chk("mid_data", bus.out_data, 0);
        chk("mid_sel0", bus.out_sel, 0);
        chk("mid_id", bus.out_id, 0);
        chk("mid_last", bus.out_last, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_grant", bus.grant, 0);
        cyc(1);
        rst = 1'b1;
        set_data(1, 4);
        bus.req = 4'b0010;
        push_job(1, 4);
        cyc(1);
        chk("post_rst_grant", bus.grant, 4'b0010);
        bus.req = '0;
        drain("drain_post_rst", 20);

        cyc(3);
        chk("final_beats", exp_q.size(), 0);
        chk("final_grants", gnt_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
